// File: rtl/decode_sequencer_if.sv
// ---------------------------------------------------------------------------
// decode_sequencer_if
//
// Bundles every handshake and SRAM bus signal exchanged between the decode
// sequencer and the rest of the top level (UART/VGA glue and the three
// milestone engines).
//
//   Sequencer control : seq_start (in), seq_busy, seq_done, seq_error (out)
//   Ownership         : owner, mult_sel (out)
//   Milestone control : M1/M2/M3_start (out), M1/M2/M3_done (in)
//   Milestone SRAM    : Mx_SRAM_address/write_data/we_n (in, x = 1..3)
//   Display SRAM      : VGA_SRAM_address (in)
//   Muxed SRAM        : SRAM_address, SRAM_write_data, SRAM_we_n (out)
//
// Modport master is the sequencer's view; slave is the surrounding top level.
// ---------------------------------------------------------------------------
interface decode_sequencer_if;
    logic        seq_start;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_error;
    logic [1:0]  owner;
    logic [1:0]  mult_sel;

    logic        M1_start;
    logic        M2_start;
    logic        M3_start;
    logic        M1_done;
    logic        M2_done;
    logic        M3_done;

    logic [17:0] M1_SRAM_address;
    logic [15:0] M1_SRAM_write_data;
    logic        M1_SRAM_we_n;
    logic [17:0] M2_SRAM_address;
    logic [15:0] M2_SRAM_write_data;
    logic        M2_SRAM_we_n;
    logic [17:0] M3_SRAM_address;
    logic [15:0] M3_SRAM_write_data;
    logic        M3_SRAM_we_n;
    logic [17:0] VGA_SRAM_address;

    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        input  seq_start,
        output seq_busy, seq_done, seq_error, owner, mult_sel,
        output M1_start, M2_start, M3_start,
        input  M1_done, M2_done, M3_done,
        input  M1_SRAM_address, M1_SRAM_write_data, M1_SRAM_we_n,
        input  M2_SRAM_address, M2_SRAM_write_data, M2_SRAM_we_n,
        input  M3_SRAM_address, M3_SRAM_write_data, M3_SRAM_we_n,
        input  VGA_SRAM_address,
        output SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        output seq_start,
        input  seq_busy, seq_done, seq_error, owner, mult_sel,
        input  M1_start, M2_start, M3_start,
        output M1_done, M2_done, M3_done,
        output M1_SRAM_address, M1_SRAM_write_data, M1_SRAM_we_n,
        output M2_SRAM_address, M2_SRAM_write_data, M2_SRAM_we_n,
        output M3_SRAM_address, M3_SRAM_write_data, M3_SRAM_we_n,
        output VGA_SRAM_address,
        input  SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/decode_sequencer.sv
// ---------------------------------------------------------------------------
// decode_sequencer
//
// Runs the decompression milestones in decode order (M3 lossless decode, M2
// IDCT, M1 colour-space conversion), each through a level start / done
// handshake. Exactly one milestone owns the SRAM port and the shared
// multipliers at any time; a one-cycle S_SWITCH gap with no owner separates
// consecutive stages so two milestones never touch SRAM back to back.
// A per-stage watchdog aborts a stage that never reports done.
//
// Parameters
//   TIMEOUT_CYCLES : watchdog limit per stage, in clock cycles
//   STAGE_MASK     : bit2 = M3, bit1 = M2, bit0 = M1; a 0 skips that stage
//
// Ports
//   CLOCK_50_I : 50 MHz clock
//   resetn     : asynchronous, active-low reset
//   bus        : decode_sequencer_if.master (handshakes + SRAM mux)
// ---------------------------------------------------------------------------
module decode_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter logic [2:0]  STAGE_MASK     = 3'b111
) (
    input  logic               CLOCK_50_I,
    input  logic               resetn,
    decode_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_M3,
        S_RUN_M2,
        S_RUN_M1,
        S_SWITCH,
        S_DONE,
        S_ERROR
    } state_t;

    // Stage codes deliberately match the owner encoding, so a stage code can
    // be written straight into owner when that stage is entered.
    localparam logic [1:0] STG_NONE = 2'd0;
    localparam logic [1:0] STG_M1   = 2'd1;
    localparam logic [1:0] STG_M2   = 2'd2;
    localparam logic [1:0] STG_M3   = 2'd3;

    state_t      state;
    logic [1:0]  next_stage;
    logic [31:0] wd_count;
    logic [1:0]  owner;
    logic [2:0]  start_r;      // {M3, M2, M1}
    logic        busy_r;
    logic        done_r;
    logic        error_r;

    logic        owner_done;
    logic [17:0] sram_address;
    logic [15:0] sram_write_data;
    logic        sram_we_n;

    // Highest-priority enabled stage among the bits of mask (M3 first).
    function automatic logic [1:0] first_enabled(input logic [2:0] mask);
        if (mask[2]) begin
            return STG_M3;
        end else if (mask[1]) begin
            return STG_M2;
        end else if (mask[0]) begin
            return STG_M1;
        end
        return STG_NONE;
    endfunction

    // Next enabled stage that follows stg in decode order, or STG_NONE.
    function automatic logic [1:0] stage_after(input logic [1:0] stg);
        logic [2:0] remaining;
        case (stg)
            STG_M3:  remaining = STAGE_MASK & 3'b011;
            STG_M2:  remaining = STAGE_MASK & 3'b001;
            default: remaining = 3'b000;
        endcase
        return first_enabled(remaining);
    endfunction

    // State reached when stage stg is entered; STG_NONE means all finished.
    function automatic state_t run_state(input logic [1:0] stg);
        case (stg)
            STG_M3:  return S_RUN_M3;
            STG_M2:  return S_RUN_M2;
            STG_M1:  return S_RUN_M1;
            default: return S_DONE;
        endcase
    endfunction

    // One-hot start vector {M3, M2, M1} for stage stg.
    function automatic logic [2:0] start_vec(input logic [1:0] stg);
        case (stg)
            STG_M3:  return 3'b100;
            STG_M2:  return 3'b010;
            STG_M1:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Only the owning milestone's done is heard; the others are ignored.
    always_comb begin
        owner_done = 1'b0;
        case (owner)
            STG_M1:  owner_done = bus.M1_done;
            STG_M2:  owner_done = bus.M2_done;
            STG_M3:  owner_done = bus.M3_done;
            default: owner_done = 1'b0;
        endcase
    end

    // Sequencer FSM with registered outputs. Every transition sets the
    // outputs that belong to the destination state, so owner/starts/busy
    // change on the same edge as the state.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            next_stage <= STG_NONE;
            wd_count   <= 32'd0;
            owner      <= STG_NONE;
            start_r    <= 3'b000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (bus.seq_start) begin
                        error_r  <= 1'b0;
                        state    <= run_state(first_enabled(STAGE_MASK));
                        owner    <= first_enabled(STAGE_MASK);
                        start_r  <= start_vec(first_enabled(STAGE_MASK));
                        busy_r   <= (first_enabled(STAGE_MASK) != STG_NONE);
                        done_r   <= (first_enabled(STAGE_MASK) == STG_NONE);
                        wd_count <= 32'd0;
                    end
                end

                S_RUN_M3, S_RUN_M2, S_RUN_M1: begin
                    // done is checked first so it wins over a coincident timeout
                    if (owner_done) begin
                        state      <= S_SWITCH;
                        next_stage <= stage_after(owner);
                        owner      <= STG_NONE;
                        start_r    <= 3'b000;
                    end else if (wd_count == TIMEOUT_CYCLES - 32'd1) begin
                        state   <= S_ERROR;
                        error_r <= 1'b1;
                        owner   <= STG_NONE;
                        start_r <= 3'b000;
                        busy_r  <= 1'b0;
                    end else begin
                        wd_count <= wd_count + 32'd1;
                    end
                end

                S_SWITCH: begin
                    state    <= run_state(next_stage);
                    owner    <= next_stage;
                    start_r  <= start_vec(next_stage);
                    busy_r   <= (next_stage != STG_NONE);
                    done_r   <= (next_stage == STG_NONE);
                    wd_count <= 32'd0;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    owner   <= STG_NONE;
                    start_r <= 3'b000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // SRAM mux: with no owner the display keeps read access and writes are
    // blocked; otherwise the owning milestone drives all three signals.
    always_comb begin
        sram_address    = bus.VGA_SRAM_address;
        sram_write_data = 16'd0;
        sram_we_n       = 1'b1;
        case (owner)
            STG_M1: begin
                sram_address    = bus.M1_SRAM_address;
                sram_write_data = bus.M1_SRAM_write_data;
                sram_we_n       = bus.M1_SRAM_we_n;
            end
            STG_M2: begin
                sram_address    = bus.M2_SRAM_address;
                sram_write_data = bus.M2_SRAM_write_data;
                sram_we_n       = bus.M2_SRAM_we_n;
            end
            STG_M3: begin
                sram_address    = bus.M3_SRAM_address;
                sram_write_data = bus.M3_SRAM_write_data;
                sram_we_n       = bus.M3_SRAM_we_n;
            end
            default: begin
                sram_address    = bus.VGA_SRAM_address;
                sram_write_data = 16'd0;
                sram_we_n       = 1'b1;
            end
        endcase
    end

    assign bus.seq_busy        = busy_r;
    assign bus.seq_done        = done_r;
    assign bus.seq_error       = error_r;
    assign bus.owner           = owner;
    assign bus.mult_sel        = owner;
    assign bus.M3_start        = start_r[2];
    assign bus.M2_start        = start_r[1];
    assign bus.M1_start        = start_r[0];
    assign bus.SRAM_address    = sram_address;
    assign bus.SRAM_write_data = sram_write_data;
    assign bus.SRAM_we_n       = sram_we_n;

endmodule

// File: tb/tb_decode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_decode_sequencer
//
// Four sequencer instances with different parameters share the milestone
// done and SRAM inputs; each has its own seq_start. Only one instance is
// started at a time, the others sit idle and ignore the shared dones.
//   inst 0 : STAGE_MASK=111, TIMEOUT_CYCLES=100
//   inst 1 : STAGE_MASK=010, TIMEOUT_CYCLES=20
//   inst 2 : STAGE_MASK=000, TIMEOUT_CYCLES=20
//   inst 3 : STAGE_MASK=111, TIMEOUT_CYCLES=20
// Observation vector: {busy, done, error, owner[1:0], M3/M2/M1_start, we_n}
// ---------------------------------------------------------------------------
module tb_decode_sequencer;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn;
    logic        start_v [4];
    logic [2:0]  m_done;            // {M3, M2, M1}
    logic [17:0] m1_addr, m2_addr, m3_addr, vga_addr;
    logic [15:0] m1_wd, m2_wd, m3_wd;
    logic        m1_we, m2_we, m3_we;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    decode_sequencer_if ia ();
    decode_sequencer_if ib ();
    decode_sequencer_if ic ();
    decode_sequencer_if id ();

    decode_sequencer #(.TIMEOUT_CYCLES(32'd100), .STAGE_MASK(3'b111))
        dut_a (.CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .bus(ia));
    decode_sequencer #(.TIMEOUT_CYCLES(32'd20), .STAGE_MASK(3'b010))
        dut_b (.CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .bus(ib));
    decode_sequencer #(.TIMEOUT_CYCLES(32'd20), .STAGE_MASK(3'b000))
        dut_c (.CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .bus(ic));
    decode_sequencer #(.TIMEOUT_CYCLES(32'd20), .STAGE_MASK(3'b111))
        dut_d (.CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .bus(id));

    assign ia.seq_start = start_v[0];
    assign ib.seq_start = start_v[1];
    assign ic.seq_start = start_v[2];
    assign id.seq_start = start_v[3];

    assign ia.M1_done = m_done[0]; assign ia.M2_done = m_done[1]; assign ia.M3_done = m_done[2];
    assign ib.M1_done = m_done[0]; assign ib.M2_done = m_done[1]; assign ib.M3_done = m_done[2];
    assign ic.M1_done = m_done[0]; assign ic.M2_done = m_done[1]; assign ic.M3_done = m_done[2];
    assign id.M1_done = m_done[0]; assign id.M2_done = m_done[1]; assign id.M3_done = m_done[2];

    assign ia.M1_SRAM_address = m1_addr; assign ia.M1_SRAM_write_data = m1_wd; assign ia.M1_SRAM_we_n = m1_we;
    assign ia.M2_SRAM_address = m2_addr; assign ia.M2_SRAM_write_data = m2_wd; assign ia.M2_SRAM_we_n = m2_we;
    assign ia.M3_SRAM_address = m3_addr; assign ia.M3_SRAM_write_data = m3_wd; assign ia.M3_SRAM_we_n = m3_we;
    assign ia.VGA_SRAM_address = vga_addr;
    assign ib.M1_SRAM_address = m1_addr; assign ib.M1_SRAM_write_data = m1_wd; assign ib.M1_SRAM_we_n = m1_we;
    assign ib.M2_SRAM_address = m2_addr; assign ib.M2_SRAM_write_data = m2_wd; assign ib.M2_SRAM_we_n = m2_we;
    assign ib.M3_SRAM_address = m3_addr; assign ib.M3_SRAM_write_data = m3_wd; assign ib.M3_SRAM_we_n = m3_we;
    assign ib.VGA_SRAM_address = vga_addr;
    assign ic.M1_SRAM_address = m1_addr; assign ic.M1_SRAM_write_data = m1_wd; assign ic.M1_SRAM_we_n = m1_we;
    assign ic.M2_SRAM_address = m2_addr; assign ic.M2_SRAM_write_data = m2_wd; assign ic.M2_SRAM_we_n = m2_we;
    assign ic.M3_SRAM_address = m3_addr; assign ic.M3_SRAM_write_data = m3_wd; assign ic.M3_SRAM_we_n = m3_we;
    assign ic.VGA_SRAM_address = vga_addr;
    assign id.M1_SRAM_address = m1_addr; assign id.M1_SRAM_write_data = m1_wd; assign id.M1_SRAM_we_n = m1_we;
    assign id.M2_SRAM_address = m2_addr; assign id.M2_SRAM_write_data = m2_wd; assign id.M2_SRAM_we_n = m2_we;
    assign id.M3_SRAM_address = m3_addr; assign id.M3_SRAM_write_data = m3_wd; assign id.M3_SRAM_we_n = m3_we;
    assign id.VGA_SRAM_address = vga_addr;

    // Expected observation vectors {busy, done, err, owner, M3s, M2s, M1s, we_n}
    localparam logic [8:0] O_IDLE = 9'b0_0_0_00_000_1;
    localparam logic [8:0] O_RUN3 = 9'b1_0_0_11_100_1;
    localparam logic [8:0] O_RUN2 = 9'b1_0_0_10_010_1;
    localparam logic [8:0] O_RUN1 = 9'b1_0_0_01_001_1;
    localparam logic [8:0] O_SW   = 9'b1_0_0_00_000_1;
    localparam logic [8:0] O_DONE = 9'b0_1_0_00_000_1;
    localparam logic [8:0] O_ERR  = 9'b0_0_1_00_000_1;

    typedef struct {
        int         inst;
        logic       start;
        logic [2:0] done;
        int         reps;
        logic [8:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic logic [8:0] get_obs(input int k);
        case (k)
            0: return {ia.seq_busy, ia.seq_done, ia.seq_error, ia.owner,
                       ia.M3_start, ia.M2_start, ia.M1_start, ia.SRAM_we_n};
            1: return {ib.seq_busy, ib.seq_done, ib.seq_error, ib.owner,
                       ib.M3_start, ib.M2_start, ib.M1_start, ib.SRAM_we_n};
            2: return {ic.seq_busy, ic.seq_done, ic.seq_error, ic.owner,
                       ic.M3_start, ic.M2_start, ic.M1_start, ic.SRAM_we_n};
            default: return {id.seq_busy, id.seq_done, id.seq_error, id.owner,
                             id.M3_start, id.M2_start, id.M1_start, id.SRAM_we_n};
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_obs(input string nm, input int k, input logic [8:0] exp);
        check(nm, {23'd0, get_obs(k)}, {23'd0, exp});
    endtask

    task automatic add(input int k, input logic st, input logic [2:0] dn,
                       input int reps, input logic [8:0] exp);
        vec_t v;
        v.inst = k; v.start = st; v.done = dn; v.reps = reps; v.exp = exp;
        vt.push_back(v);
    endtask

    // Drive inputs for the next rising edge, then move to the following
    // falling edge where outputs are sampled.
    task automatic step(input int k, input logic st, input logic [2:0] dn);
        for (int j = 0; j < 4; j++) start_v[j] = (j == k) ? st : 1'b0;
        m_done = dn;
        @(negedge CLOCK_50_I);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench time limit");
    end

    initial begin
        resetn = 1'b0;
        for (int j = 0; j < 4; j++) start_v[j] = 1'b0;
        m_done   = 3'b000;
        m1_addr  = 18'h00011; m1_wd = 16'h00F0; m1_we = 1'b1;
        m2_addr  = 18'h02222; m2_wd = 16'h5A5A; m2_we = 1'b1;
        m3_addr  = 18'h01234; m3_wd = 16'hBEEF; m3_we = 1'b1;
        vga_addr = 18'h3ABCD;

        // Reset state
        repeat (2) @(negedge CLOCK_50_I);
        for (int k = 0; k < 4; k++) check_obs($sformatf("reset_obs%0d", k), k, O_IDLE);
        check("reset_addr", {14'd0, ia.SRAM_address}, {14'd0, vga_addr});
        check("reset_mult_sel", {30'd0, ia.mult_sel}, 32'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50_I);

        // inst 0: full run M3 (10 cycles) -> M2 (5) -> M1 (3)
        add(0, 1'b1, 3'b000, 1, O_RUN3);
        add(0, 1'b0, 3'b000, 7, O_RUN3);
        add(0, 1'b0, 3'b011, 2, O_RUN3);   // non-owner dones ignored
        add(0, 1'b0, 3'b100, 1, O_SW);
        add(0, 1'b0, 3'b000, 1, O_RUN2);
        add(0, 1'b1, 3'b000, 4, O_RUN2);   // seq_start while busy ignored
        add(0, 1'b0, 3'b010, 1, O_SW);
        add(0, 1'b0, 3'b000, 1, O_RUN1);
        add(0, 1'b0, 3'b000, 2, O_RUN1);
        add(0, 1'b0, 3'b001, 1, O_SW);
        add(0, 1'b0, 3'b000, 1, O_DONE);
        add(0, 1'b1, 3'b000, 1, O_IDLE);   // seq_start during S_DONE ignored
        add(0, 1'b0, 3'b000, 1, O_IDLE);
        // inst 1: only M2 enabled
        add(1, 1'b1, 3'b000, 1, O_RUN2);
        add(1, 1'b0, 3'b101, 2, O_RUN2);
        add(1, 1'b0, 3'b000, 2, O_RUN2);
        add(1, 1'b0, 3'b010, 1, O_SW);
        add(1, 1'b0, 3'b000, 1, O_DONE);
        add(1, 1'b0, 3'b000, 1, O_IDLE);
        // inst 2: no stage enabled
        add(2, 1'b1, 3'b000, 1, O_DONE);
        add(2, 1'b0, 3'b000, 2, O_IDLE);

        for (int i = 0; i < vt.size(); i++) begin
            for (int r = 0; r < vt[i].reps; r++) begin
                step(vt[i].inst, vt[i].start, vt[i].done);
                check_obs($sformatf("vec%0d.%0d", i, r), vt[i].inst, vt[i].exp);
            end
        end

        // SRAM / multiplier mux on inst 0
        m1_we = 1'b0; m2_we = 1'b0; m3_we = 1'b0;
        #1;
        check("mux_idle_addr", {14'd0, ia.SRAM_address}, {14'd0, vga_addr});
        check("mux_idle_we", {31'd0, ia.SRAM_we_n}, 32'd1);
        check("mux_idle_wd", {16'd0, ia.SRAM_write_data}, 32'd0);
        step(0, 1'b1, 3'b000);
        check("mux_m3_addr", {14'd0, ia.SRAM_address}, 32'h01234);
        check("mux_m3_wd", {16'd0, ia.SRAM_write_data}, 32'hBEEF);
        check("mux_m3_we", {31'd0, ia.SRAM_we_n}, 32'd0);
        check("mux_m3_sel", {30'd0, ia.mult_sel}, 32'd3);
        step(0, 1'b0, 3'b100);
        check("mux_sw_addr", {14'd0, ia.SRAM_address}, {14'd0, vga_addr});
        check("mux_sw_we", {31'd0, ia.SRAM_we_n}, 32'd1);
        check("mux_sw_wd", {16'd0, ia.SRAM_write_data}, 32'd0);
        check("mux_sw_sel", {30'd0, ia.mult_sel}, 32'd0);
        step(0, 1'b0, 3'b000);
        check("mux_m2_addr", {14'd0, ia.SRAM_address}, 32'h02222);
        check("mux_m2_wd", {16'd0, ia.SRAM_write_data}, 32'h5A5A);
        check("mux_m2_sel", {30'd0, ia.mult_sel}, 32'd2);
        step(0, 1'b0, 3'b010);
        check("mux_sw2_we", {31'd0, ia.SRAM_we_n}, 32'd1);
        step(0, 1'b0, 3'b000);
        check("mux_m1_addr", {14'd0, ia.SRAM_address}, 32'h00011);
        check("mux_m1_wd", {16'd0, ia.SRAM_write_data}, 32'h00F0);
        check("mux_m1_sel", {30'd0, ia.mult_sel}, 32'd1);
        step(0, 1'b0, 3'b001);
        step(0, 1'b0, 3'b000);
        check_obs("mux_done", 0, O_DONE);
        step(0, 1'b0, 3'b000);
        m1_we = 1'b1; m2_we = 1'b1; m3_we = 1'b1;

        // inst 3: M2 never completes -> watchdog abort 20 cycles after start
        step(3, 1'b1, 3'b000); check_obs("to_run3", 3, O_RUN3);
        step(3, 1'b0, 3'b000); check_obs("to_run3b", 3, O_RUN3);
        step(3, 1'b0, 3'b100); check_obs("to_sw", 3, O_SW);
        step(3, 1'b0, 3'b000); check_obs("to_run2", 3, O_RUN2);
        for (int c = 1; c < 20; c++) begin
            step(3, 1'b0, 3'b000);
            check_obs($sformatf("to_wait%0d", c), 3, O_RUN2);
        end
        step(3, 1'b0, 3'b000); check_obs("to_error", 3, O_ERR);
        step(3, 1'b0, 3'b000); check_obs("to_sticky", 3, O_ERR);
        step(3, 1'b0, 3'b010); check_obs("to_late_done", 3, O_ERR);
        step(3, 1'b1, 3'b000); check_obs("to_restart", 3, O_RUN3);

        // Reset mid-M2 on the edge where done and timeout coincide
        step(3, 1'b0, 3'b100); check_obs("rst_sw", 3, O_SW);
        step(3, 1'b0, 3'b000); check_obs("rst_run2", 3, O_RUN2);
        for (int c = 1; c < 20; c++) step(3, 1'b0, 3'b000);
        check_obs("rst_pre", 3, O_RUN2);
        m_done = 3'b010;
        resetn = 1'b0;
        #1;
        check_obs("rst_async", 3, O_IDLE);
        check("rst_addr", {14'd0, id.SRAM_address}, {14'd0, vga_addr});
        check("rst_sel", {30'd0, id.mult_sel}, 32'd0);
        @(negedge CLOCK_50_I);
        check_obs("rst_held", 3, O_IDLE);
        resetn = 1'b1;
        step(3, 1'b0, 3'b000); check_obs("rst_release", 3, O_IDLE);

        // Done and timeout on the same edge: done wins, no error
        step(3, 1'b1, 3'b000); check_obs("co_run3", 3, O_RUN3);
        step(3, 1'b0, 3'b100); check_obs("co_sw", 3, O_SW);
        step(3, 1'b0, 3'b000); check_obs("co_run2", 3, O_RUN2);
        for (int c = 1; c < 20; c++) step(3, 1'b0, 3'b000);
        check_obs("co_pre", 3, O_RUN2);
        step(3, 1'b0, 3'b010); check_obs("co_sw2", 3, O_SW);
        step(3, 1'b0, 3'b000); check_obs("co_run1", 3, O_RUN1);
        step(3, 1'b0, 3'b001); check_obs("co_sw3", 3, O_SW);
        step(3, 1'b0, 3'b000); check_obs("co_done", 3, O_DONE);
        step(3, 1'b0, 3'b000); check_obs("co_idle", 3, O_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
